// File: rtl/airlock_pkg.sv
// Shared airlock definitions: FSM state encoding, default timing constants
// and the output decode used by the airlock sequence controllers.
package airlock_pkg;

    // 3-bit state encoding shared by fill/pressurize and drain/depressurize.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_VENT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    // Default timing constants, shared with the fill/pressurize controller.
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int VENT_TIMEOUT_DEF = 8;
    localparam int CNT_W_DEF        = 4;

    // Valve and status outputs driven by the drain/depressurize sequence.
    typedef struct packed {
        logic drain;
        logic vent;
        logic done;
        logic fault;
    } dd_out_t;

    // Moore decode: each output depends on the state code only.
    // Unused codes decode to all-off so the valves stay closed.
    function automatic dd_out_t decode_state(input logic [2:0] st);
        dd_out_t o;
        o = '{drain: 1'b0, vent: 1'b0, done: 1'b0, fault: 1'b0};
        case (st)
            ST_DRAIN: o.drain = 1'b1;
            ST_VENT:  o.vent  = 1'b1;
            ST_DONE:  o.done  = 1'b1;
            ST_FAULT: o.fault = 1'b1;
            default:  o = '{drain: 1'b0, vent: 1'b0, done: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// Saturating up-counter for airlock phase timing. Synchronous clear wins
// over enable; the count sticks at all-ones instead of wrapping.
module airlock_timer
    import airlock_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count register: async clear on reset, sync clear, saturating increment.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/drain_and_depressurize.sv
// Airlock exit-direction controller: drains the sealed chamber for a fixed
// number of cycles, vents until the pressure sensor clears, then reports done.
// Optional build macro DANDD_VENT_TIMEOUT_EN: faults if VENT lasts
// VENT_TIMEOUT cycles with the chamber still pressurized.
module drain_and_depressurize
    import airlock_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int VENT_TIMEOUT = VENT_TIMEOUT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic begin_DandD,
    input  logic InnerClosed,
    input  logic OuterClosed,
    input  logic Pressurized,
    output logic Drain,
    output logic Vent,
    output logic DandD_Done,
    output logic Fault
);

    localparam int MAX_TICKS = (DRAIN_CYCLES > VENT_TIMEOUT) ? DRAIN_CYCLES : VENT_TIMEOUT;

    // Reject parameter sets the counter cannot represent.
    if ((DRAIN_CYCLES < 1) || ((MAX_TICKS - 1) >= (1 << CNT_W))) begin : g_param_check
        $error("drain_and_depressurize: DRAIN_CYCLES must be >= 1 and CNT_W must hold max(DRAIN_CYCLES, VENT_TIMEOUT)-1");
    end

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
`ifdef DANDD_VENT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] VENT_LAST  = CNT_W'(VENT_TIMEOUT - 1);
`endif

    logic [2:0]       r_state;
    dd_out_t          r_out;
    logic [2:0]       w_next;
    dd_out_t          w_next_out;
    logic             w_clr;
    logic             w_en;
    logic             w_sealed;
    logic [CNT_W-1:0] w_count;

    assign w_sealed = InnerClosed & OuterClosed;

    // Phase counter: cleared on every phase entry, counts while draining/venting.
    airlock_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_count)
    );

    // Next-state and counter control. In DRAIN/VENT a door opening beats
    // everything, then (with the timeout) a stuck vent, then a withdrawn request.
    always_comb begin
        w_next = ST_IDLE;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (begin_DandD && w_sealed && Pressurized) begin
                    w_next = ST_DRAIN;
                    w_clr  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Pressure is deliberately ignored here: the drain always runs its full count.
                if (!w_sealed) begin
                    w_next = ST_FAULT;
                end else if (!begin_DandD) begin
                    w_next = ST_IDLE;
                end else if (w_count == DRAIN_LAST) begin
                    w_next = ST_VENT;
                    w_clr  = 1'b1;
                end else begin
                    w_next = ST_DRAIN;
                    w_en   = 1'b1;
                end
            end
            ST_VENT: begin
                if (!w_sealed) begin
                    w_next = ST_FAULT;
`ifdef DANDD_VENT_TIMEOUT_EN
                end else if (Pressurized && (w_count == VENT_LAST)) begin
                    w_next = ST_FAULT;
`endif
                end else if (!begin_DandD) begin
                    w_next = ST_IDLE;
                end else if (!Pressurized) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_VENT;
                    w_en   = 1'b1;
                end
            end
            ST_DONE: begin
                // Doors are not watched: the outer door is expected to open now.
                if (!begin_DandD) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_FAULT: begin
                if (!begin_DandD && w_sealed) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_FAULT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_next_out = decode_state(w_next);

    // State and output registers; outputs are the decode of the state being
    // entered, so they track r_state exactly and clear asynchronously on reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_out   <= '{drain: 1'b0, vent: 1'b0, done: 1'b0, fault: 1'b0};
        end else begin
            r_state <= w_next;
            r_out   <= w_next_out;
        end
    end

    assign Drain      = r_out.drain;
    assign Vent       = r_out.vent;
    assign DandD_Done = r_out.done;
    assign Fault      = r_out.fault;

endmodule

// File: tb/tb_drain_and_depressurize.sv
// Table-driven bench for drain_and_depressurize with an expected-value queue.
// Inputs are packed {begin_DandD, InnerClosed, OuterClosed, Pressurized};
// outputs are packed {Drain, Vent, DandD_Done, Fault}.
module tb_drain_and_depressurize;

    logic Clock = 1'b0;
    logic Reset;
    logic begin_DandD;
    logic InnerClosed;
    logic OuterClosed;
    logic Pressurized;
    logic Drain;
    logic Vent;
    logic DandD_Done;
    logic Fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] in;
        logic [3:0] exp;
        string      tag;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_q[$];

    drain_and_depressurize #(
        .DRAIN_CYCLES (4),
        .VENT_TIMEOUT (8),
        .CNT_W        (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .begin_DandD (begin_DandD),
        .InnerClosed (InnerClosed),
        .OuterClosed (OuterClosed),
        .Pressurized (Pressurized),
        .Drain       (Drain),
        .Vent        (Vent),
        .DandD_Done  (DandD_Done),
        .Fault       (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: drain/vent/done/fault got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one input vector, queue its expected response, clock, compare.
    task automatic step(input logic [3:0] in, input logic [3:0] exp, input string name);
        logic [3:0] e;
        {begin_DandD, InnerClosed, OuterClosed, Pressurized} = in;
        sb_q.push_back(exp);
        @(posedge Clock);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check4(name, {Drain, Vent, DandD_Done, Fault}, e);
        end
    endtask

    task automatic add(input logic [3:0] in, input logic [3:0] exp, input string tag);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        // Nominal: 4 drain cycles, vent until pressure clears, done, release.
        add(4'b1111, 4'b1000, "nom_drain1");
        add(4'b1111, 4'b1000, "nom_drain2");
        add(4'b1111, 4'b1000, "nom_drain3");
        add(4'b1111, 4'b1000, "nom_drain4");
        add(4'b1111, 4'b0100, "nom_vent1");
        add(4'b1111, 4'b0100, "nom_vent2");
        add(4'b1111, 4'b0100, "nom_vent3");
        add(4'b1110, 4'b0010, "nom_done");
        add(4'b1100, 4'b0010, "done_door_open_ok");
        add(4'b0110, 4'b0000, "done_to_idle");
        // Guards in IDLE.
        add(4'b1110, 4'b0000, "guard_no_press");
        add(4'b1011, 4'b0000, "guard_inner_open");
        add(4'b1101, 4'b0000, "guard_outer_open");
        // Door opens in DRAIN; fault holds until request dropped with doors sealed.
        add(4'b1111, 4'b1000, "df_drain1");
        add(4'b1111, 4'b1000, "df_drain2");
        add(4'b1101, 4'b0001, "df_fault");
        add(4'b1111, 4'b0001, "df_hold_begin");
        add(4'b0101, 4'b0001, "df_hold_unsealed");
        add(4'b0111, 4'b0000, "df_clear");
        // Abort in VENT.
        add(4'b1111, 4'b1000, "ab_drain1");
        add(4'b1111, 4'b1000, "ab_drain2");
        add(4'b1111, 4'b1000, "ab_drain3");
        add(4'b1111, 4'b1000, "ab_drain4");
        add(4'b1111, 4'b0100, "ab_vent");
        add(4'b0111, 4'b0000, "ab_idle");
        // Pressure loss during DRAIN is ignored.
        add(4'b1111, 4'b1000, "pd_drain1");
        add(4'b1110, 4'b1000, "pd_drain2");
        add(4'b1110, 4'b1000, "pd_drain3");
        add(4'b1110, 4'b1000, "pd_drain4");
        add(4'b1110, 4'b0100, "pd_vent");
        add(4'b1110, 4'b0010, "pd_done");
        add(4'b0111, 4'b0000, "pd_idle");
        // Door opens on the edge the drain count completes.
        add(4'b1111, 4'b1000, "sd_drain1");
        add(4'b1111, 4'b1000, "sd_drain2");
        add(4'b1111, 4'b1000, "sd_drain3");
        add(4'b1111, 4'b1000, "sd_drain4");
        add(4'b1011, 4'b0001, "sd_fault_not_vent");
        add(4'b0111, 4'b0000, "sd_idle");
        // Pressure clears and door opens together in VENT.
        add(4'b1111, 4'b1000, "sv_drain1");
        add(4'b1111, 4'b1000, "sv_drain2");
        add(4'b1111, 4'b1000, "sv_drain3");
        add(4'b1111, 4'b1000, "sv_drain4");
        add(4'b1111, 4'b0100, "sv_vent");
        add(4'b1100, 4'b0001, "sv_fault");
        add(4'b0111, 4'b0000, "sv_idle");
        // Abort during DRAIN.
        add(4'b1111, 4'b1000, "ad_drain1");
        add(4'b0111, 4'b0000, "ad_idle");

        Reset = 1'b0;
        {begin_DandD, InnerClosed, OuterClosed, Pressurized} = 4'b0000;
        #12;
        check4("reset_outputs", {Drain, Vent, DandD_Done, Fault}, 4'b0000);
        @(negedge Clock);
        Reset = 1'b1;
        step(4'b0111, 4'b0000, "idle_after_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in, vecs[i].exp, $sformatf("%s[%0d]", vecs[i].tag, i));
        end

        // Asynchronous reset mid-DRAIN closes the drain valve before any edge.
        step(4'b1111, 4'b1000, "ar_drain1");
        step(4'b1111, 4'b1000, "ar_drain2");
        #2;
        Reset = 1'b0;
        #1;
        check4("ar_async_drain_off", {Drain, Vent, DandD_Done, Fault}, 4'b0000);
        begin_DandD = 1'b0;
        @(negedge Clock);
        check4("ar_held_in_reset", {Drain, Vent, DandD_Done, Fault}, 4'b0000);
        Reset = 1'b1;
        step(4'b0111, 4'b0000, "ar_idle_after_release");

        // Vent with pressure stuck high.
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b1000, $sformatf("to_drain%0d", i));
        end
        step(4'b1111, 4'b0100, "to_vent_c1");
`ifdef DANDD_VENT_TIMEOUT_EN
        for (int i = 2; i <= 8; i++) begin
            step(4'b1111, 4'b0100, $sformatf("to_vent_c%0d", i));
        end
        step(4'b1111, 4'b0001, "to_timeout_fault");
        step(4'b0111, 4'b0000, "to_idle");
`else
        for (int i = 2; i <= 21; i++) begin
            step(4'b1111, 4'b0100, $sformatf("to_vent_c%0d", i));
        end
        step(4'b1110, 4'b0010, "to_late_done");
        step(4'b0111, 4'b0000, "to_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
